// File: rtl/matrix_transfer_ctrl.sv
// matrix_transfer_ctrl
//
// Moves N x N matrices between a synchronous data RAM and the packed matrix
// buses of the coprocessor, under a start/busy/done handshake.
//   LOAD  (op 2'b00): reads A from BASE_A and B from BASE_B into shadow
//                     buffers. matriz1_o/matriz2_o update together on the
//                     edge that raises done_o.
//   STORE (op 2'b01): snapshots matriz_resultante_i at acceptance and writes
//                     it to RAM starting at BASE_R, one element per cycle.
//   op 2'b1x:         no RAM access; err_o and done_o pulse together.
// Packing is row-major with element k = r*N+c at bits [k*ELEM_W +: ELEM_W].
//
// Optional feature macro: MTX_SIZE_SEL_EN. When defined, size_i selects the
// active dimension m (latched at acceptance; 0 or >N clamps to N). RAM is then
// read/written as a compact m x m block, while the buses keep N-stride packing
// with zeros outside the window. When undefined, m = N.
//
// Ports:
//   clk_i                system clock, rising edge
//   rst_n                asynchronous active-low reset
//   start_i              command strobe, sampled only in idle
//   op_i                 command code
//   size_i               active dimension (MTX_SIZE_SEL_EN only)
//   matriz_resultante_i  result matrix to store
//   matriz1_o/matriz2_o  matrix A / matrix B (double-buffered)
//   busy_o               high while a command executes
//   done_o               one-cycle completion pulse
//   err_o                one-cycle pulse with done_o for an invalid op
//   ram_addr_o/ram_we_o/ram_wdata_o  RAM request
//   ram_rdata_i          RAM read data, one cycle after the address

module matrix_transfer_ctrl #(
    parameter int unsigned N      = 5,
    parameter int unsigned ELEM_W = 8,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned BASE_A = 0,
    parameter int unsigned BASE_B = 25,
    parameter int unsigned BASE_R = 50
) (
    input  logic                       clk_i,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic [1:0]                 op_i,
`ifdef MTX_SIZE_SEL_EN
    input  logic [$clog2(N+1)-1:0]     size_i,
`endif
    input  logic [N*N*ELEM_W-1:0]      matriz_resultante_i,
    output logic [N*N*ELEM_W-1:0]      matriz1_o,
    output logic [N*N*ELEM_W-1:0]      matriz2_o,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    output logic [ADDR_W-1:0]          ram_addr_o,
    output logic                       ram_we_o,
    output logic [ELEM_W-1:0]          ram_wdata_o,
    input  logic [ELEM_W-1:0]          ram_rdata_i
);

    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned MW = N * N * ELEM_W;
    localparam int unsigned NE = N * N;

    typedef enum logic [2:0] {
        StIdle,
        StLoadIssue,
        StLoadDrain,
        StStore,
        StErr,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ELEM_W-1:0] wdata_q, wdata_d;
    // Position (sel, r, c) of the element currently addressed.
    logic [CW-1:0]     r_q, r_d, c_q, c_d;
    logic              sel_q, sel_d;
    // Position of the element whose read data arrives this cycle.
    logic              pend_v_q, pend_v_d;
    logic              pend_sel_q, pend_sel_d;
    logic [CW-1:0]     pend_r_q, pend_r_d, pend_c_q, pend_c_d;
    logic [MW-1:0]     shadow_a_q, shadow_a_d, shadow_b_q, shadow_b_d;
    logic [MW-1:0]     mat1_q, mat1_d, mat2_q, mat2_d;
    logic [MW-1:0]     snap_q, snap_d;
    logic              err_q, err_d;

    logic [CW-1:0]     m;
    logic [CW-1:0]     m_last;
    logic              last_c, last_r, wrap;
    logic [CW-1:0]     c_nx, r_nx;
    int unsigned       pidx, nidx;

`ifdef MTX_SIZE_SEL_EN
    logic [CW-1:0] m_q, m_d, size_clamp;

    assign size_clamp = (size_i == '0 || size_i > CW'(N)) ? CW'(N) : size_i;
    assign m          = m_q;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            m_q <= CW'(N);
        end else begin
            m_q <= m_d;
        end
    end
`else
    assign m = CW'(N);
`endif

    // Row-major walk over the active m x m window.
    assign m_last = m - CW'(1);
    assign last_c = (c_q == m_last);
    assign last_r = (r_q == m_last);
    assign wrap   = last_c && last_r;
    assign c_nx   = last_c ? '0 : c_q + CW'(1);
    assign r_nx   = last_c ? (last_r ? '0 : r_q + CW'(1)) : r_q;

    // Slots in the N-stride bus layout.
    assign pidx = 32'(pend_r_q) * N + 32'(pend_c_q);
    assign nidx = 32'(r_nx) * N + 32'(c_nx);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        r_d        = r_q;
        c_d        = c_q;
        sel_d      = sel_q;
        pend_v_d   = 1'b0;
        pend_sel_d = pend_sel_q;
        pend_r_d   = pend_r_q;
        pend_c_d   = pend_c_q;
        shadow_a_d = shadow_a_q;
        shadow_b_d = shadow_b_q;
        mat1_d     = mat1_q;
        mat2_d     = mat2_q;
        snap_d     = snap_q;
        err_d      = err_q;
`ifdef MTX_SIZE_SEL_EN
        m_d        = m_q;
`endif

        // Capture read data for the address issued in the previous cycle.
        if (pend_v_q) begin
            for (int unsigned k = 0; k < NE; k++) begin
                if (k == pidx) begin
                    if (pend_sel_q) begin
                        shadow_b_d[k*ELEM_W +: ELEM_W] = ram_rdata_i;
                    end else begin
                        shadow_a_d[k*ELEM_W +: ELEM_W] = ram_rdata_i;
                    end
                end
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    r_d   = '0;
                    c_d   = '0;
                    sel_d = 1'b0;
                    err_d = 1'b0;
`ifdef MTX_SIZE_SEL_EN
                    m_d   = size_clamp;
`endif
                    if (op_i[1]) begin
                        state_d = StErr;
                        err_d   = 1'b1;
                    end else if (op_i[0]) begin
                        state_d = StStore;
                        addr_d  = ADDR_W'(BASE_R);
                        snap_d  = matriz_resultante_i;
                        wdata_d = matriz_resultante_i[ELEM_W-1:0];
                    end else begin
                        state_d    = StLoadIssue;
                        addr_d     = ADDR_W'(BASE_A);
                        // Clearing here gives zeros outside the active window.
                        shadow_a_d = '0;
                        shadow_b_d = '0;
                    end
                end
            end

            StLoadIssue: begin
                pend_v_d   = 1'b1;
                pend_sel_d = sel_q;
                pend_r_d   = r_q;
                pend_c_d   = c_q;
                r_d        = r_nx;
                c_d        = c_nx;
                if (wrap) begin
                    if (sel_q) begin
                        state_d = StLoadDrain;
                    end else begin
                        sel_d  = 1'b1;
                        addr_d = ADDR_W'(BASE_B);
                    end
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end

            StLoadDrain: begin
                // shadow_*_d already holds the final element.
                state_d = StDone;
                mat1_d  = shadow_a_d;
                mat2_d  = shadow_b_d;
            end

            StStore: begin
                if (wrap) begin
                    state_d = StDone;
                end else begin
                    r_d    = r_nx;
                    c_d    = c_nx;
                    addr_d = addr_q + ADDR_W'(1);
                    for (int unsigned k = 0; k < NE; k++) begin
                        if (k == nidx) begin
                            wdata_d = snap_q[k*ELEM_W +: ELEM_W];
                        end
                    end
                end
            end

            StErr: begin
                state_d = StDone;
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            wdata_q    <= '0;
            r_q        <= '0;
            c_q        <= '0;
            sel_q      <= 1'b0;
            pend_v_q   <= 1'b0;
            pend_sel_q <= 1'b0;
            pend_r_q   <= '0;
            pend_c_q   <= '0;
            shadow_a_q <= '0;
            shadow_b_q <= '0;
            mat1_q     <= '0;
            mat2_q     <= '0;
            snap_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            r_q        <= r_d;
            c_q        <= c_d;
            sel_q      <= sel_d;
            pend_v_q   <= pend_v_d;
            pend_sel_q <= pend_sel_d;
            pend_r_q   <= pend_r_d;
            pend_c_q   <= pend_c_d;
            shadow_a_q <= shadow_a_d;
            shadow_b_q <= shadow_b_d;
            mat1_q     <= mat1_d;
            mat2_q     <= mat2_d;
            snap_q     <= snap_d;
            err_q      <= err_d;
        end
    end

    // Decoded from state so a reset removes the write strobe immediately.
    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StDone);
    assign err_o       = (state_q == StDone) && err_q;
    assign ram_we_o    = (state_q == StStore);
    assign ram_addr_o  = addr_q;
    assign ram_wdata_o = wdata_q;
    assign matriz1_o   = mat1_q;
    assign matriz2_o   = mat2_q;

endmodule
